// File: rtl/ntt_core_seq.sv
// Sequenced NTT core for one RNS modulus lane.
// Holds a ping-pong store of 2^LOG_DEPTH packed coefficient pairs {b,a} and,
// after a start pulse, runs NUM_STAGES butterfly passes through an external
// pipelined butterfly. Each pass reads the active bank, writes the other bank,
// then swaps, so the final result always sits in the active bank.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   start, mode          run request (IDLE only), twiddle offset mode
//   busy, done, log_m    run status, one-cycle done pulse, current stage
//   load_*               host write into the active bank (IDLE only)
//   unload_addr/_data    host read of the active bank, 1-cycle latency
//   tw_addr, tw_data     combinational twiddle ROM interface
//   bf_valid, bf_a/b/w   butterfly operands
//   bf_A, bf_B           butterfly results, BF_LATENCY cycles after bf_valid
module ntt_core_seq #(
  parameter int unsigned DATA_WIDTH     = 30,
  parameter int unsigned LOG_DEPTH      = 9,
  parameter int unsigned LOG_CORE_COUNT = 5,
  parameter int unsigned CORE_INDEX     = 0,
  parameter int unsigned TW_ADDR_WIDTH  = 12,
  parameter int unsigned BF_LATENCY     = 4,
  parameter int unsigned NUM_STAGES     = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [1:0]                 mode,
  output logic                       busy,
  output logic                       done,
  output logic [3:0]                 log_m,
  input  logic                       load_en,
  input  logic [LOG_DEPTH-1:0]       load_addr,
  input  logic [2*DATA_WIDTH-1:0]    load_data,
  input  logic [LOG_DEPTH-1:0]       unload_addr,
  output logic [2*DATA_WIDTH-1:0]    unload_data,
  output logic [TW_ADDR_WIDTH-1:0]   tw_addr,
  input  logic [DATA_WIDTH-1:0]      tw_data,
  output logic                       bf_valid,
  output logic [DATA_WIDTH-1:0]      bf_a,
  output logic [DATA_WIDTH-1:0]      bf_b,
  output logic [DATA_WIDTH-1:0]      bf_w,
  input  logic [DATA_WIDTH-1:0]      bf_A,
  input  logic [DATA_WIDTH-1:0]      bf_B
);

  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned LD    = LOG_DEPTH;
  localparam int unsigned TW    = TW_ADDR_WIDTH;
  localparam int unsigned DEPTH = 1 << LOG_DEPTH;
  localparam int unsigned CNT_W = $clog2(BF_LATENCY + 2);
  localparam logic [TW-1:0] ODD_OFF = ((CORE_INDEX % 2) == 1) ? TW'(2) : TW'(0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_DRAIN = 3'd2,
    S_SWAP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  logic                r_sel;
  logic [1:0]          r_mode;
  logic [3:0]          r_log_m;
  logic [LD-1:0]       r_raddr;
  logic [LD-1:0]       r_rd_addr;
  logic [CNT_W-1:0]    r_drain;
  logic                r_vld_dly  [BF_LATENCY];
  logic [LD-1:0]       r_addr_dly [BF_LATENCY];
  logic [2*W-1:0]      r_mem [2][DEPTH];

  logic                w_we;
  logic                w_wbank;
  logic [LD-1:0]       w_waddr;
  logic [2*W-1:0]      w_wdata;
  logic [2*W-1:0]      w_rd_pair;
  logic [TW-1:0]       w_base;
  logic [TW-1:0]       w_off;
  logic [TW-1:0]       w_raddr_ext;

  assign log_m     = r_log_m;
  assign w_rd_pair = r_mem[r_sel][r_raddr];

  // Twiddle address: stage base plus mode-dependent per-address offset
  always_comb begin
    w_raddr_ext = TW'(r_raddr);
    w_base      = (TW'(1) << r_log_m) + ((TW'(CORE_INDEX) << r_log_m) >> LOG_CORE_COUNT);
    case (r_mode)
      2'd1:    w_off = w_raddr_ext << 1;
      2'd2:    w_off = (w_raddr_ext << 2) + ODD_OFF;
      default: w_off = '0;
    endcase
    tw_addr = w_base + w_off;
  end

  // Single RAM write port: host loads only in IDLE, stage writes only while busy
  always_comb begin
    w_we    = 1'b0;
    w_wbank = r_sel;
    w_waddr = load_addr;
    w_wdata = load_data;
    if (r_state == S_IDLE && load_en) begin
      w_we = 1'b1;
    end else if (r_vld_dly[BF_LATENCY-1]) begin
      w_we    = 1'b1;
      w_wbank = ~r_sel;
      w_waddr = r_addr_dly[BF_LATENCY-1];
      w_wdata = {bf_B, bf_A};
    end
  end

  // Coefficient store; gated by rst_n so a reset edge lands no write
  always_ff @(posedge clk) begin
    if (rst_n && w_we) r_mem[w_wbank][w_waddr] <= w_wdata;
  end

  // Sequencer, operand registers, result delay line and unload port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sel       <= 1'b0;
      r_mode      <= 2'd0;
      r_log_m     <= 4'd0;
      r_raddr     <= '0;
      r_rd_addr   <= '0;
      r_drain     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      bf_valid    <= 1'b0;
      bf_a        <= '0;
      bf_b        <= '0;
      bf_w        <= '0;
      unload_data <= '0;
      for (int unsigned i = 0; i < BF_LATENCY; i++) begin
        r_vld_dly[i]  <= 1'b0;
        r_addr_dly[i] <= '0;
      end
    end else begin
      done        <= 1'b0;
      bf_valid    <= 1'b0;
      unload_data <= r_mem[r_sel][unload_addr];

      // Tracks each issued address until its butterfly result returns
      r_vld_dly[0]  <= bf_valid;
      r_addr_dly[0] <= r_rd_addr;
      for (int unsigned i = 1; i < BF_LATENCY; i++) begin
        r_vld_dly[i]  <= r_vld_dly[i-1];
        r_addr_dly[i] <= r_addr_dly[i-1];
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_READ;
            r_mode  <= mode;
            r_log_m <= 4'd0;
            r_raddr <= '0;
            busy    <= 1'b1;
          end
        end
        S_READ: begin
          bf_valid  <= 1'b1;
          bf_a      <= w_rd_pair[W-1:0];
          bf_b      <= w_rd_pair[2*W-1:W];
          bf_w      <= tw_data;
          r_rd_addr <= r_raddr;
          if (r_raddr == LD'(DEPTH - 1)) begin
            r_state <= S_DRAIN;
            r_drain <= '0;
          end else begin
            r_raddr <= r_raddr + LD'(1);
          end
        end
        S_DRAIN: begin
          // Last result lands at the end of the final drain cycle
          if (r_drain == CNT_W'(BF_LATENCY)) r_state <= S_SWAP;
          else                               r_drain <= r_drain + CNT_W'(1);
        end
        S_SWAP: begin
          r_sel <= ~r_sel;
          if (r_log_m == 4'(NUM_STAGES - 1)) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            r_state <= S_READ;
            r_log_m <= r_log_m + 4'd1;
            r_raddr <= '0;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ntt_core_seq.md
Name: ntt_core_seq

Overview:
Parametrised successor of the fixed-size NTT core, for one RNS modulus lane of the accelerator. Holds a ping-pong coefficient store of 2^LOG_DEPTH packed pairs and sequences NUM_STAGES butterfly passes autonomously after a start pulse. Generates twiddle ROM addresses per stage and mode. Drives an external pipelined butterfly (ct_butterfly-compatible) and writes its results back.

Parameters:
DATA_WIDTH, 30, coefficient width W; a pair is 2W bits, a in [W-1:0], b in [2W-1:W]
LOG_DEPTH, 9, log2 of pair entries per bank (DEPTH = 2^LOG_DEPTH)
LOG_CORE_COUNT, 5, log2 of cores sharing the transform
CORE_INDEX, 0, index of this core, 0..2^LOG_CORE_COUNT-1
TW_ADDR_WIDTH, 12, twiddle ROM address width
BF_LATENCY, 4, cycles from bf_valid to valid bf_A/bf_B (>=1)
NUM_STAGES, 10, passes per run; log_m runs 0..NUM_STAGES-1

Ports:
clk  in  1  clock, all logic rising-edge
rst_n  in  1  synchronous active-low reset
start  in  1  run request, sampled only in IDLE
mode  in  2  twiddle offset mode, sampled at start
busy  out  1  high from cycle after start accept until done
done  out  1  one-cycle pulse at run end
log_m  out  4  current stage index
load_en  in  1  write load_data to active bank, ignored when busy
load_addr  in  LOG_DEPTH  load address
load_data  in  2W  packed pair
unload_addr  in  LOG_DEPTH  read address, active bank
unload_data  out  2W  registered read data, 1-cycle latency
tw_addr  out  TW_ADDR_WIDTH  twiddle ROM address (combinational ROM)
tw_data  in  W  twiddle ROM data
bf_valid  out  1  bf_a/bf_b/bf_w valid
bf_a, bf_b, bf_w  out  W each  butterfly operands
bf_A, bf_B  in  W each  butterfly results, BF_LATENCY after bf_valid

Behaviour:
- Reset (rst_n=0 at edge): state IDLE, sel=0, busy=0, done=0, log_m=0, bf_valid=0, bf_a/bf_b/bf_w=0, unload_data=0, read counter=0, valid delay line cleared. RAM contents are not cleared. Mid-run reset aborts immediately; no further writes.
- Banks: bank[sel] is active. It takes load/unload and is the stage read source. bank[~sel] is the stage write target. sel toggles at every SWAP. After a run, the result is in the active bank.
- Twiddle index, truncated to TW_ADDR_WIDTH: base = (1<<log_m) + ((CORE_INDEX<<log_m)>>LOG_CORE_COUNT), plus an offset.
  - mode 0: offset 0.
  - mode 1: offset raddr<<1.
  - mode 2: offset (raddr<<2) + (CORE_INDEX odd ? 2 : 0).
  - mode 3: treated as mode 0.
- Pipeline per address k, read issued cycle t:
  - t: tw_addr presented.
  - t+1: RAM data and tw_data registered; bf_a/bf_b/bf_w driven; bf_valid=1.
  - t+1+BF_LATENCY: {bf_B,bf_A} written to bank[~sel][k].
- FSM:
  - IDLE: start=1 → READ; log_m=0, raddr=0, mode latched. Load/unload permitted.
  - READ: one address per cycle for DEPTH cycles. On raddr=DEPTH-1 → DRAIN.
  - DRAIN: 1+BF_LATENCY cycles until the last write lands → SWAP.
  - SWAP: 1 cycle. Toggle sel. If log_m=NUM_STAGES-1 → DONE, else log_m+1, raddr=0 → READ.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- busy=1 in READ/DRAIN/SWAP.
- Cycles per stage: DEPTH+BF_LATENCY+2. done is high in cycle 1+NUM_STAGES*(DEPTH+BF_LATENCY+2) after the start-accept cycle (cycle 0).
- Ignored inputs: start outside IDLE (including the DONE cycle), load_en while busy or in DONE. Load and unload to the same address in one cycle returns old data.
- Width rules: all index arithmetic is unsigned and wraps modulo 2^TW_ADDR_WIDTH. log_m is zero-extended.

Test Plan:
1. Params LOG_DEPTH=2, BF_LATENCY=2, NUM_STAGES=2, mode 0, CORE_INDEX 0. Bench ROM tw_data=10*addr, loopback model A=a+w, B=b. Load addr0 a=5,b=7 → done at cycle 17; unload addr0 gives a=35, b=7; tw_addr=1 in stage 0 and 2 in stage 1.
2. Same bench, mode 1 → stage-0 tw_addr sequence 1,3,5,7; stage 1 sequence 2,4,6,8.
3. CORE_INDEX=1, mode 2, LOG_CORE_COUNT=1 → stage-0 tw_addr 3,7,11,15.
4. rst_n=0 during stage 1 READ → next cycle busy=0, bf_valid=0, state IDLE; a new start completes normally in 17 cycles.
5. start held high across the whole run, plus load_en pulses while busy → exactly one done; RAM is unaffected by the loads; restart is accepted only the cycle after DONE.
6. Unload after reset with no run → data comes from bank 0, 1-cycle latency, and matches the loaded values.
